// File: rtl/bcd2b_pkg.sv
// Shared types, widths and result resolution for the BCD-to-binary converter.
package bcd2b_pkg;

   localparam int unsigned OUT_W         = 8;
   localparam int unsigned BCD_W         = 12;
   localparam int unsigned ACC_W         = 10;
   localparam int unsigned DIG_W         = 4;
   localparam int unsigned BCD_DIGIT_MAX = 9;
   localparam int unsigned BIN_MAX       = 255;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CONV_T = 2'd1,
      CONV_L = 2'd2
   } state_t;

   typedef struct packed {
      logic [OUT_W-1:0] val;
      logic             err;
      logic             ovf;
   } chan_res_t;

   // Invalid digits win over overflow; overflow clamps or wraps depending on sat.
   function automatic chan_res_t resolve(input logic [ACC_W-1:0] acc,
                                         input logic             bad,
                                         input logic             sat);
      chan_res_t r;
      r.val = '0;
      r.err = 1'b0;
      r.ovf = 1'b0;
      if (bad) begin
         r.err = 1'b1;
      end else if (acc > ACC_W'(BIN_MAX)) begin
         r.ovf = 1'b1;
         r.val = sat ? OUT_W'(BIN_MAX) : acc[OUT_W-1:0];
      end else begin
         r.val = acc[OUT_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd2b_step.sv
// One decimal multiply-accumulate step: acc*10 + digit, with a bad-digit flag.
module bcd2b_step
   import bcd2b_pkg::*;
(
   input  logic [ACC_W-1:0] acc,
   input  logic [DIG_W-1:0] digit,
   output logic [ACC_W-1:0] acc_next,
   output logic             digit_bad
);

   assign acc_next  = (acc << 3) + (acc << 1) + ACC_W'(digit);
   assign digit_bad = (digit > DIG_W'(BCD_DIGIT_MAX));

endmodule

// File: rtl/bcd2b.sv
// Iterative two-channel packed-BCD to binary converter, one digit per clock,
// T channel first then L, with start/busy/done handshake.
module bcd2b
   import bcd2b_pkg::*;
#(
   parameter bit SAT = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [BCD_W-1:0]   DT,
   input  logic [BCD_W-1:0]   DL,
   output logic [OUT_W-1:0]   T,
   output logic [OUT_W-1:0]   L,
   output logic               busy,
   output logic               done,
   output logic [1:0]         err,
   output logic [1:0]         ovf
);

   state_t             state;
   logic [1:0]         idx;
   logic [BCD_W-1:0]   dt_q;
   logic [BCD_W-1:0]   dl_q;
   logic [ACC_W-1:0]   acc;
   logic               bad;
   chan_res_t          t_hold;

   logic [BCD_W-1:0]   src;
   logic [DIG_W-1:0]   digit;
   logic [ACC_W-1:0]   acc_next;
   logic               digit_bad;
   logic               bad_fin;
   chan_res_t          res;

   // Current digit of the channel being converted, hundreds first.
   always_comb begin
      src   = (state == CONV_L) ? dl_q : dt_q;
      digit = src[3:0];
      case (idx)
         2'd2:    digit = src[11:8];
         2'd1:    digit = src[7:4];
         default: digit = src[3:0];
      endcase
   end

   bcd2b_step u_step (
      .acc       (acc),
      .digit     (digit),
      .acc_next  (acc_next),
      .digit_bad (digit_bad)
   );

   assign bad_fin = bad | digit_bad;
   assign res     = resolve(acc_next, bad_fin, SAT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         idx    <= 2'd0;
         dt_q   <= '0;
         dl_q   <= '0;
         acc    <= '0;
         bad    <= 1'b0;
         t_hold <= '0;
         T      <= '0;
         L      <= '0;
         err    <= 2'b00;
         ovf    <= 2'b00;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  dt_q  <= DT;
                  dl_q  <= DL;
                  acc   <= '0;
                  bad   <= 1'b0;
                  idx   <= 2'd2;
                  busy  <= 1'b1;
                  state <= CONV_T;
               end
            end
            CONV_T: begin
               if (idx == 2'd0) begin
                  t_hold <= res;
                  acc    <= '0;
                  bad    <= 1'b0;
                  idx    <= 2'd2;
                  state  <= CONV_L;
               end else begin
                  acc <= acc_next;
                  bad <= bad_fin;
                  idx <= 2'(idx - 2'd1);
               end
            end
            CONV_L: begin
               // Last L digit: publish both channels at once.
               if (idx == 2'd0) begin
                  T     <= t_hold.val;
                  L     <= res.val;
                  err   <= {res.err, t_hold.err};
                  ovf   <= {res.ovf, t_hold.ovf};
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  acc   <= '0;
                  bad   <= 1'b0;
                  state <= IDLE;
               end else begin
                  acc <= acc_next;
                  bad <= bad_fin;
                  idx <= 2'(idx - 2'd1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd2b.sv
// Scoreboard bench for bcd2b: saturating and wrapping instances share stimulus.
module tb_bcd2b;

   logic        clk;
   logic        rst;
   logic        start;
   logic [11:0] DT;
   logic [11:0] DL;
   logic [7:0]  t1, l1, t0, l0;
   logic        busy1, done1, busy0, done0;
   logic [1:0]  err1, ovf1, err0, ovf0;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [7:0] t1, l1, t0, l0;
      logic [1:0] err, ovf;
      int         e0;
   } exp_t;

   exp_t sb[$];

   bcd2b #(.SAT(1'b1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .DT(DT), .DL(DL),
      .T(t1), .L(l1), .busy(busy1), .done(done1), .err(err1), .ovf(ovf1)
   );

   bcd2b #(.SAT(1'b0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .DT(DT), .DL(DL),
      .T(t0), .L(l0), .busy(busy0), .done(done0), .err(err0), .ovf(ovf0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Drives a start pulse into E0; optionally records the expected result.
   task automatic issue(input logic [11:0] dt, input logic [11:0] dl,
                        input logic [7:0] et1, input logic [7:0] el1,
                        input logic [7:0] et0, input logic [7:0] el0,
                        input logic [1:0] eerr, input logic [1:0] eovf,
                        input bit push);
      exp_t e;
      DT    = dt;
      DL    = dl;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      DT    = 12'hFFF;
      DL    = 12'hFFF;
      chk("busy_after_start", int'(busy1), 1);
      if (push) begin
         e.t1 = et1; e.l1 = el1; e.t0 = et0; e.l0 = el0;
         e.err = eerr; e.ovf = eovf; e.e0 = cyc;
         sb.push_back(e);
      end
   endtask

   // Monitor: pop and compare whenever the DUT presents done.
   bit prev_done = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_done <= 1'b0;
      end else begin
         if (prev_done) chk("done_one_cycle", int'(done1), 0);
         if (done1) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("T_sat",      int'(t1),   int'(e.t1));
               chk("L_sat",      int'(l1),   int'(e.l1));
               chk("err_sat",    int'(err1), int'(e.err));
               chk("ovf_sat",    int'(ovf1), int'(e.ovf));
               chk("T_wrap",     int'(t0),   int'(e.t0));
               chk("L_wrap",     int'(l0),   int'(e.l0));
               chk("err_wrap",   int'(err0), int'(e.err));
               chk("ovf_wrap",   int'(ovf0), int'(e.ovf));
               chk("done_wrap",  int'(done0), 1);
               chk("busy_at_done", int'(busy1), 0);
               chk("latency",    cyc, e.e0 + 6);
            end
         end
         prev_done <= done1;
      end
   end

   initial begin
      logic [11:0] tbl [3];
      logic [7:0]  tval [3];
      int k;
      tbl[0] = 12'h123; tval[0] = 8'd123;
      tbl[1] = 12'h200; tval[1] = 8'd200;
      tbl[2] = 12'h087; tval[2] = 8'd87;

      rst = 1'b1; start = 1'b0; DT = '0; DL = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_T", int'(t1), 0);
      chk("rst_L", int'(l1), 0);
      chk("rst_err", int'(err1), 0);
      chk("rst_ovf", int'(ovf1), 0);
      chk("rst_busy", int'(busy1), 0);
      chk("rst_done", int'(done1), 0);
      @(posedge clk); #1;

      issue(12'h255, 12'h009, 8'd255, 8'd9,   8'd255, 8'd9,   2'b00, 2'b00, 1'b1);
      repeat (7) @(posedge clk); #1;
      issue(12'h256, 12'h999, 8'd255, 8'd255, 8'd0,   8'd231, 2'b00, 2'b11, 1'b1);
      repeat (7) @(posedge clk); #1;
      issue(12'h1A3, 12'h100, 8'd0,   8'd100, 8'd0,   8'd100, 2'b01, 2'b00, 1'b1);
      repeat (7) @(posedge clk); #1;
      issue(12'h000, 12'h9F0, 8'd0,   8'd0,   8'd0,   8'd0,   2'b10, 2'b00, 1'b1);
      repeat (7) @(posedge clk); #1;

      // start held high; only every 7th edge should capture DT.
      for (int i = 0; i < 21; i++) begin
         k = i / 7;
         DT    = (i % 7 == 0) ? tbl[k] : 12'hFFF;
         DL    = 12'h050;
         start = 1'b1;
         @(posedge clk);
         #1;
         if (i % 7 == 0) begin
            exp_t e;
            e.t1 = tval[k]; e.l1 = 8'd50; e.t0 = tval[k]; e.l0 = 8'd50;
            e.err = 2'b00; e.ovf = 2'b00; e.e0 = cyc;
            sb.push_back(e);
         end
      end
      start = 1'b0;
      repeat (3) @(posedge clk); #1;

      // Abort a conversion between E3 and E4.
      issue(12'h777, 12'h111, 8'd0, 8'd0, 8'd0, 8'd0, 2'b00, 2'b00, 1'b0);
      repeat (3) @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("abort_busy", int'(busy1), 0);
      chk("abort_done", int'(done1), 0);
      chk("abort_T", int'(t1), 0);
      chk("abort_L", int'(l1), 0);
      chk("abort_err", int'(err1), 0);
      chk("abort_ovf", int'(ovf1), 0);
      #2;
      rst = 1'b0;
      repeat (3) @(posedge clk); #1;
      chk("abort_no_done", int'(done1), 0);

      issue(12'h042, 12'h128, 8'd42, 8'd128, 8'd42, 8'd128, 2'b00, 2'b00, 1'b1);

      for (int w = 0; w < 40 && sb.size() != 0; w++) @(posedge clk);
      repeat (2) @(posedge clk);
      chk("scoreboard_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
